// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game sequencer.
// Holds game states, direction encodings and the speed-up period helper.
package snake_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        OVER
    } game_state_t;

    typedef logic [1:0] dir_t;

    localparam dir_t DIR_UP    = 2'b01;
    localparam dir_t DIR_DOWN  = 2'b00;
    localparam dir_t DIR_LEFT  = 2'b10;
    localparam dir_t DIR_RIGHT = 2'b11;

    // Opposite directions share the axis bit and differ in the sense bit.
    function automatic logic is_reverse(input dir_t req, input dir_t cur);
        return (req[1] == cur[1]) && (req[0] != cur[0]);
    endfunction

    function automatic logic [31:0] speed_period(
        input logic [31:0] base,
        input logic [31:0] min_p,
        input logic [31:0] step,
        input logic [7:0]  score
    );
        logic [31:0] cut;
        cut = 32'(score) * step;
        if (cut >= base - min_p)
            return min_p;
        return base - cut;
    endfunction

endpackage

// File: rtl/snake_game_ctrl_if.sv
// Link between the game sequencer and the snake datapath.
// master = sequencer side, slave = datapath side.
interface snake_game_ctrl_if;
    import snake_pkg::*;

    logic start;
    logic update;
    dir_t direction;
    logic good_collision;
    logic game_over_hit;

    modport master (
        output start,
        output update,
        output direction,
        input  good_collision,
        input  game_over_hit
    );

    modport slave (
        input  start,
        input  update,
        input  direction,
        output good_collision,
        output game_over_hit
    );

endinterface

// File: rtl/snake_tick_gen.sv
// Programmable divider: one-cycle tick every `period` clocks while run.
// The count is held at zero whenever run is low.
module snake_tick_gen (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic [31:0] period,
    output logic        tick
);

    logic [31:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (!run) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count >= period - 32'd1) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + 32'd1;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/snake_game_ctrl.sv
// Snake game sequencer: play/over FSM, update strobe, turn filter, score.
// Optional SNAKE_SPEEDUP_EN shortens the tick period as apples are eaten.
module snake_game_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 5_000_000,
    parameter int unsigned MIN_TICK    = 1_000_000,
    parameter int unsigned SPEED_STEP  = 250_000,
    parameter int unsigned MAX_SCORE   = 127
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_btn,
    input  dir_t              dir_req,
    input  logic              dir_valid,
    output logic [7:0]        score,
    output logic              apple_respawn,
    output logic              win,
    snake_game_ctrl_if.master dp
);

    localparam logic [31:0] TICK_P = 32'(TICK_CYCLES);
    localparam logic [7:0]  MAX_S  = 8'(MAX_SCORE);

    game_state_t state;
    logic        start_q;
    logic        btn_q;
    logic        btn_rise;
    logic        apple_seen;
    logic        tick;
    logic        update;
    logic        take;
    dir_t        direction;
    dir_t        pending;
    logic [31:0] period;

    assign update       = tick && (state == PLAY);
    assign dp.start     = start_q;
    assign dp.update    = update;
    assign dp.direction = direction;

    // A lethal hit in the same cycle cancels the apple.
    assign take = (state == PLAY) && dp.good_collision
               && !dp.game_over_hit && !apple_seen;

    snake_tick_gen u_tick (
        .clk    (clk),
        .reset  (reset),
        .run    (state == PLAY),
        .period (period),
        .tick   (tick)
    );

`ifdef SNAKE_SPEEDUP_EN
    // Reload only on update so a running interval is never shortened.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            period <= TICK_P;
        else if (state != PLAY)
            period <= TICK_P;
        else if (update)
            period <= speed_period(TICK_P, 32'(MIN_TICK),
                                   32'(SPEED_STEP), score);
    end
`else
    logic [63:0] unused_cfg;
    assign unused_cfg = {32'(MIN_TICK), 32'(SPEED_STEP)};
    assign period     = TICK_P;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            start_q       <= 1'b0;
            btn_q         <= 1'b0;
            btn_rise      <= 1'b0;
            apple_seen    <= 1'b0;
            direction     <= DIR_RIGHT;
            pending       <= DIR_RIGHT;
            score         <= '0;
            apple_respawn <= 1'b0;
            win           <= 1'b0;
        end else begin
            btn_q         <= start_btn;
            btn_rise      <= start_btn & ~btn_q;
            apple_respawn <= 1'b0;
            unique case (state)
                IDLE: begin
                    score      <= '0;
                    win        <= 1'b0;
                    apple_seen <= 1'b0;
                    direction  <= DIR_RIGHT;
                    pending    <= DIR_RIGHT;
                    if (btn_rise) begin
                        state   <= PLAY;
                        start_q <= 1'b1;
                    end
                end
                PLAY: begin
                    if (dir_valid && !is_reverse(dir_req, direction))
                        pending <= dir_req;
                    if (update)
                        direction <= pending;
                    if (take) begin
                        score         <= (score < MAX_S) ? score + 8'd1 : score;
                        apple_respawn <= 1'b1;
                    end
                    apple_seen <= update ? 1'b0 : (apple_seen | take);
                    if (dp.game_over_hit) begin
                        state   <= OVER;
                        start_q <= 1'b0;
                    end else if (score == MAX_S) begin
                        state   <= OVER;
                        start_q <= 1'b0;
                        win     <= 1'b1;
                    end
                end
                OVER: begin
                    if (btn_rise)
                        state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    start_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_game_ctrl.sv
// Directed bench for snake_game_ctrl (TICK_CYCLES=8, MIN_TICK=4, SPEED_STEP=2).
// Expected interval lengths follow SNAKE_SPEEDUP_EN when it is defined.
module tb_snake_game_ctrl;
    import snake_pkg::*;

`ifdef SNAKE_SPEEDUP_EN
    localparam int EXP_P1 = 6;
    localparam int EXP_P2 = 4;
`else
    localparam int EXP_P1 = 8;
    localparam int EXP_P2 = 8;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_btn;
    dir_t       dir_req;
    logic       dir_valid;
    logic [7:0] score;
    logic       apple_respawn;
    logic       win;

    int checks   = 0;
    int failures = 0;
    int pulses;
    int ups;
    int n;

    snake_game_ctrl_if dp ();

    snake_game_ctrl #(
        .TICK_CYCLES (8),
        .MIN_TICK    (4),
        .SPEED_STEP  (2),
        .MAX_SCORE   (127)
    ) dut (
        .clk           (clk),
        .reset         (rst_n),
        .start_btn     (start_btn),
        .dir_req       (dir_req),
        .dir_valid     (dir_valid),
        .score         (score),
        .apple_respawn (apple_respawn),
        .win           (win),
        .dp            (dp)
    );

    always #5 clk = ~clk;

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_update();
        int k = 0;
        do begin
            step(1);
            k++;
        end while (!dp.update && k < 40);
        check("wait_update", {31'd0, dp.update}, 32'd1);
    endtask

    // Cycles from the current update to the next one; optional apple.
    task automatic measure(input bit eat, output int cnt);
        cnt = 0;
        repeat (40) begin
            step(1);
            cnt++;
            if (dp.update)
                break;
            dp.good_collision = eat && (cnt == 1);
        end
        dp.good_collision = 1'b0;
    endtask

    initial begin
        rst_n              = 1'b0;
        start_btn          = 1'b0;
        dir_req            = DIR_DOWN;
        dir_valid          = 1'b0;
        dp.good_collision  = 1'b0;
        dp.game_over_hit   = 1'b0;
        step(2);
        check("rst_start", {31'd0, dp.start}, 32'd0);
        check("rst_update", {31'd0, dp.update}, 32'd0);
        check("rst_dir", {30'd0, dp.direction}, 32'd3);
        check("rst_score", {24'd0, score}, 32'd0);
        check("rst_respawn", {31'd0, apple_respawn}, 32'd0);
        check("rst_win", {31'd0, win}, 32'd0);
        rst_n = 1'b1;
        step(2);

        start_btn = 1'b1;
        step(1);
        check("start_early", {31'd0, dp.start}, 32'd0);
        step(1);
        check("start_on", {31'd0, dp.start}, 32'd1);
        check("dir_init", {30'd0, dp.direction}, 32'd3);
        step(7);
        check("upd_before", {31'd0, dp.update}, 32'd0);
        step(1);
        check("upd_first", {31'd0, dp.update}, 32'd1);
        step(1);
        check("upd_one_cycle", {31'd0, dp.update}, 32'd0);
        step(7);
        check("upd_second", {31'd0, dp.update}, 32'd1);

        dir_valid = 1'b1;
        dir_req   = DIR_LEFT;
        step(1);
        dir_req = DIR_UP;
        step(1);
        dir_req = DIR_DOWN;
        step(1);
        dir_valid = 1'b0;
        check("dir_no_early", {30'd0, dp.direction}, 32'd3);
        wait_update();
        check("dir_on_update", {30'd0, dp.direction}, 32'd3);
        step(1);
        check("dir_last_wins", {30'd0, dp.direction}, 32'd0);
        dir_valid = 1'b1;
        dir_req   = DIR_UP;
        step(1);
        dir_valid = 1'b0;
        wait_update();
        step(1);
        check("dir_rev_drop", {30'd0, dp.direction}, 32'd0);
        dir_valid = 1'b1;
        dir_req   = DIR_LEFT;
        step(1);
        dir_valid = 1'b0;
        wait_update();
        step(1);
        check("dir_left", {30'd0, dp.direction}, 32'd2);

        pulses = 0;
        dp.good_collision = 1'b1;
        repeat (5) begin
            step(1);
            pulses += int'(apple_respawn);
        end
        dp.good_collision = 1'b0;
        step(1);
        pulses += int'(apple_respawn);
        check("apple_score1", {24'd0, score}, 32'd1);
        check("apple_pulses", pulses, 32'd1);
        wait_update();
        step(1);
        dp.good_collision = 1'b1;
        step(3);
        dp.good_collision = 1'b0;
        step(1);
        check("apple_score2", {24'd0, score}, 32'd2);

        start_btn = 1'b0;
        step(2);
        start_btn = 1'b1;
        step(3);
        check("btn_in_play", {31'd0, dp.start}, 32'd1);
        start_btn = 1'b0;

        wait_update();
        step(2);
        dp.good_collision = 1'b1;
        dp.game_over_hit  = 1'b1;
        step(1);
        check("hit_start", {31'd0, dp.start}, 32'd0);
        check("hit_score", {24'd0, score}, 32'd2);
        check("hit_respawn", {31'd0, apple_respawn}, 32'd0);
        dp.good_collision = 1'b0;
        dp.game_over_hit  = 1'b0;
        ups = 0;
        repeat (20) begin
            step(1);
            ups += int'(dp.update);
        end
        check("over_no_update", ups, 32'd0);
        check("over_score_held", {24'd0, score}, 32'd2);

        start_btn = 1'b1;
        step(3);
        check("idle_score", {24'd0, score}, 32'd0);
        check("idle_start", {31'd0, dp.start}, 32'd0);
        start_btn = 1'b0;
        step(2);
        start_btn = 1'b1;
        step(3);
        check("restart", {31'd0, dp.start}, 32'd1);

        wait_update();
        measure(1'b1, n);
        check("period_running", n, 32'd8);
        measure(1'b1, n);
        check("period_score1", n, EXP_P1);
        measure(1'b0, n);
        check("period_score2", n, EXP_P2);
        check("speed_score", {24'd0, score}, 32'd2);

        for (int i = 0; i < 125; i++) begin
            wait_update();
            step(1);
            dp.good_collision = 1'b1;
            step(1);
            dp.good_collision = 1'b0;
        end
        check("max_score", {24'd0, score}, 32'd127);
        step(1);
        check("win_set", {31'd0, win}, 32'd1);
        check("win_start", {31'd0, dp.start}, 32'd0);

        #3;
        rst_n = 1'b0;
        #1;
        check("async_win", {31'd0, win}, 32'd0);
        check("async_score", {24'd0, score}, 32'd0);
        check("async_dir", {30'd0, dp.direction}, 32'd3);
        step(2);
        rst_n     = 1'b1;
        start_btn = 1'b0;
        step(2);
        start_btn = 1'b1;
        step(3);
        check("restart2", {31'd0, dp.start}, 32'd1);
        wait_update();
        step(3);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_start", {31'd0, dp.start}, 32'd0);
        check("async_update", {31'd0, dp.update}, 32'd0);
        check("async_respawn", {31'd0, apple_respawn}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
